clic_arb_sched: RTL and testbench

Sequential interrupt arbiter for the CLIC. Scans all pending, enabled sources and selects the one with the highest priority above the current threshold, then presents it to the core over a valid/ready claim handshake. The same argmax selection is used elsewhere in the design. This block adds the sequencing around it: scan control, candidate latching, claim, and pending-clear generation.

---
 rtl/clic_arb_sched_pkg.sv | 50 +++++
 rtl/clic_cand_cmp.sv | 23 ++
 rtl/clic_arb_sched.sv | 129 ++++++++++++
 tb/tb_clic_arb_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clic_arb_sched_pkg.sv
// Shared types and helpers for the CLIC arbiter/scheduler.
// The tree-argmax helper is used only when CLIC_ARB_TREE_EN is defined.
package clic_arb_sched_pkg;

  localparam int unsigned CLIC_NUM_SRC = 16;
  localparam int unsigned CLIC_PRIO_W  = 8;
  localparam int unsigned CLIC_ID_W    = $clog2(CLIC_NUM_SRC);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PRESENT = 2'd2,
    CLEAR   = 2'd3
  } clic_arb_state_e;

  typedef struct packed {
    logic                   found;
    logic [CLIC_PRIO_W-1:0] prio;
    logic [CLIC_ID_W-1:0]   id;
  } clic_cand_t;

  // A source may win only if pending, enabled and strictly above threshold
  function automatic logic clic_eligible(input logic                   pending,
                                         input logic                   enable,
                                         input logic [CLIC_PRIO_W-1:0] prio,
                                         input logic [CLIC_PRIO_W-1:0] threshold);
    return pending & enable & (prio > threshold);
  endfunction

  // Binary-tree argmax; the lower-index half is kept on ties
  function automatic clic_cand_t clic_tree_argmax(
      input logic [CLIC_NUM_SRC-1:0]             elig,
      input logic [CLIC_NUM_SRC*CLIC_PRIO_W-1:0] prio);
    clic_cand_t nodes [CLIC_NUM_SRC];
    for (int unsigned i = 0; i < CLIC_NUM_SRC; i++) begin
      nodes[i].found = elig[i];
      nodes[i].prio  = elig[i] ? prio[i*CLIC_PRIO_W +: CLIC_PRIO_W] : '0;
      nodes[i].id    = CLIC_ID_W'(i);
    end
    for (int unsigned step = 1; step < CLIC_NUM_SRC; step = step * 2) begin
      for (int unsigned i = 0; i + step < CLIC_NUM_SRC; i = i + 2 * step) begin
        if (nodes[i+step].found && (!nodes[i].found || (nodes[i+step].prio > nodes[i].prio))) begin
          nodes[i] = nodes[i+step];
        end
      end
    end
    return nodes[0];
  endfunction

endpackage

// File: rtl/clic_cand_cmp.sv
// Candidate-vs-source compare: replaces the running best on a strictly higher
// eligible priority, so ties stay with the earlier (lower) index.
module clic_cand_cmp
  import clic_arb_sched_pkg::*;
(
  input  clic_cand_t             cand,
  input  logic                   src_elig,
  input  logic [CLIC_PRIO_W-1:0] src_prio,
  input  logic [CLIC_ID_W-1:0]   src_id,
  output clic_cand_t             cand_next_c
);

  // Update the candidate when the scanned source beats it
  always_comb begin
    cand_next_c = cand;
    if (src_elig && (!cand.found || (src_prio > cand.prio))) begin
      cand_next_c.found = 1'b1;
      cand_next_c.prio  = src_prio;
      cand_next_c.id    = src_id;
    end
  end

endmodule

// File: rtl/clic_arb_sched.sv
// CLIC interrupt arbiter/scheduler: scan, present over valid/ready, clear.
// Optional macro CLIC_ARB_TREE_EN: single-cycle tree reduction instead of
// the one-source-per-cycle sequential scan.
module clic_arb_sched
  import clic_arb_sched_pkg::*;
#(
  parameter int unsigned NUM_SRC = CLIC_NUM_SRC,
  parameter int unsigned PRIO_W  = CLIC_PRIO_W,
  parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_pending,
  input  logic [NUM_SRC-1:0]        src_enable,
  input  logic [NUM_SRC*PRIO_W-1:0] src_prio,
  input  logic [PRIO_W-1:0]         threshold,
  output logic                      irq_valid,
  output logic [ID_W-1:0]           irq_id,
  output logic [PRIO_W-1:0]         irq_prio,
  input  logic                      irq_ready,
  output logic [NUM_SRC-1:0]        src_clear,
  output logic                      busy
);

  clic_arb_state_e      state;
  logic [PRIO_W-1:0]    prio_arr [NUM_SRC];
  logic [NUM_SRC-1:0]   elig_c;
  logic                 any_elig_c;
  logic                 held_elig_c;
  clic_cand_t           scan_c;
  logic                 last_c;

  // Per-source live eligibility
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign prio_arr[i] = src_prio[i*PRIO_W +: PRIO_W];
    assign elig_c[i]   = clic_eligible(src_pending[i], src_enable[i],
                                       CLIC_PRIO_W'(prio_arr[i]),
                                       CLIC_PRIO_W'(threshold));
  end

  assign any_elig_c  = |elig_c;
  assign held_elig_c = elig_c[irq_id];

`ifdef CLIC_ARB_TREE_EN
  // Whole vector reduced in the single SCAN cycle
  assign scan_c = clic_tree_argmax(elig_c, src_prio);
  assign last_c = 1'b1;
`else
  logic [ID_W-1:0] idx;
  clic_cand_t      cand;

  clic_cand_cmp u_cand_cmp (
    .cand        (cand),
    .src_elig    (elig_c[idx]),
    .src_prio    (CLIC_PRIO_W'(prio_arr[idx])),
    .src_id      (CLIC_ID_W'(idx)),
    .cand_next_c (scan_c)
  );

  assign last_c = (idx == ID_W'(NUM_SRC - 1));

  // Scan index and running candidate; reset on every IDLE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      cand <= '0;
    end else if (state == SCAN) begin
      idx  <= ID_W'(idx + ID_W'(1));
      cand <= scan_c;
    end else begin
      idx  <= '0;
      cand <= '0;
    end
  end
`endif

  // Scheduler FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      irq_valid <= 1'b0;
      irq_id    <= '0;
      irq_prio  <= '0;
      src_clear <= '0;
      busy      <= 1'b0;
    end else begin
      src_clear <= '0;
      case (state)
        IDLE: begin
          if (any_elig_c) begin
            state <= SCAN;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (last_c) begin
            busy <= 1'b0;
            if (scan_c.found) begin
              state     <= PRESENT;
              irq_valid <= 1'b1;
              irq_id    <= ID_W'(scan_c.id);
              irq_prio  <= PRIO_W'(scan_c.prio);
            end else begin
              state <= IDLE;
            end
          end
        end
        PRESENT: begin
          // Claim takes precedence over withdrawal
          if (irq_ready) begin
            state     <= CLEAR;
            irq_valid <= 1'b0;
            src_clear <= NUM_SRC'(1) << irq_id;
          end else if (!held_elig_c) begin
            state     <= IDLE;
            irq_valid <= 1'b0;
          end
        end
        CLEAR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clic_arb_sched.sv
// Scoreboard bench for clic_arb_sched; expected grants/clears are queued by
// the stimulus and consumed by an independent negedge monitor.
module tb_clic_arb_sched;

  localparam int unsigned NUM_SRC = 16;
  localparam int unsigned PRIO_W  = 8;
  localparam int unsigned ID_W    = 4;
`ifdef CLIC_ARB_TREE_EN
  localparam int unsigned LAT      = 2;
  localparam int unsigned SCAN_CYC = 1;
  localparam int unsigned RST_DLY  = 1;
`else
  localparam int unsigned LAT      = NUM_SRC + 1;
  localparam int unsigned SCAN_CYC = NUM_SRC;
  localparam int unsigned RST_DLY  = 8;
`endif

  logic                      clk;
  logic                      rst;
  logic [NUM_SRC-1:0]        src_pending;
  logic [NUM_SRC-1:0]        src_enable;
  logic [NUM_SRC*PRIO_W-1:0] src_prio;
  logic [PRIO_W-1:0]         threshold;
  logic                      irq_valid;
  logic [ID_W-1:0]           irq_id;
  logic [PRIO_W-1:0]         irq_prio;
  logic                      irq_ready;
  logic [NUM_SRC-1:0]        src_clear;
  logic                      busy;

  clic_arb_sched dut (
    .clk         (clk),
    .rst         (rst),
    .src_pending (src_pending),
    .src_enable  (src_enable),
    .src_prio    (src_prio),
    .threshold   (threshold),
    .irq_valid   (irq_valid),
    .irq_id      (irq_id),
    .irq_prio    (irq_prio),
    .irq_ready   (irq_ready),
    .src_clear   (src_clear),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    int          prio;
    int unsigned at;
  } grant_t;

  grant_t            exp_grant [$];
  logic [NUM_SRC-1:0] exp_clear [$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares every grant and clear pulse against the queues
  initial begin
    bit     prev;
    grant_t g;
    grant_t cur;
    logic [NUM_SRC-1:0] c;
    prev = 1'b0;
    cur  = '{0, 0, 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (irq_valid && !prev) begin
          if (exp_grant.size() == 0) begin
            check("unexpected_grant", irq_id, -1);
          end else begin
            g   = exp_grant.pop_front();
            cur = g;
            check("grant_id", irq_id, g.id);
            check("grant_prio", irq_prio, g.prio);
            check("grant_latency", cyc, g.at);
          end
        end else if (irq_valid) begin
          check("held_id", irq_id, cur.id);
          check("held_prio", irq_prio, cur.prio);
        end
        if (src_clear != '0) begin
          if (exp_clear.size() == 0) begin
            check("unexpected_clear", src_clear, 0);
          end else begin
            c = exp_clear.pop_front();
            check("src_clear", src_clear, c);
          end
        end
        prev = irq_valid;
      end
    end
  end

  task automatic clear_inputs();
    src_pending = '0;
    src_enable  = '0;
    src_prio    = '0;
    threshold   = '0;
    irq_ready   = 1'b0;
  endtask

  task automatic set_src(input int i, input int p);
    src_pending[i]           = 1'b1;
    src_enable[i]            = 1'b1;
    src_prio[i*PRIO_W +: PRIO_W] = PRIO_W'(p);
  endtask

  task automatic expect_grant(input int id, input int p);
    exp_grant.push_back('{id, p, cyc + LAT});
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (irq_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(name, 0, 1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_valid"}, irq_valid, 0);
    check({name, "_id"}, irq_id, 0);
    check({name, "_prio"}, irq_prio, 0);
    check({name, "_clear"}, src_clear, 0);
    check({name, "_busy"}, busy, 0);
  endtask

  // Claim the presented interrupt; pending is dropped as the clear lands
  task automatic claim(input int id);
    logic [NUM_SRC-1:0] one;
    one = NUM_SRC'(1);
    irq_ready = 1'b1;
    exp_clear.push_back(one << id);
    @(negedge clk);
    irq_ready   = 1'b0;
    src_pending = '0;
    check("valid_low_in_clear", irq_valid, 0);
    repeat (3) @(negedge clk);
    check("idle_after_clear", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int cnt;
    rst = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single source 5 at prio 3; hold ready low a few cycles, then claim
    set_src(5, 3);
    expect_grant(5, 3);
    wait_valid("s1_timeout", ok);
    if (ok) begin
      repeat (3) @(negedge clk);
      claim(5);
    end
    clear_inputs();
    @(negedge clk);

    // Tie between 2 and 9 at prio 7 goes to 2; 4 at prio 6 loses
    set_src(2, 7);
    set_src(9, 7);
    set_src(4, 6);
    expect_grant(2, 7);
    wait_valid("s2_timeout", ok);
    if (ok) claim(2);
    clear_inputs();
    @(negedge clk);

    // Threshold 7: prio 7 is not strictly above, prio 8 wins
    threshold = 8'd7;
    set_src(1, 7);
    set_src(3, 8);
    expect_grant(3, 8);
    wait_valid("s3_timeout", ok);
    if (ok) claim(3);

    // Threshold 8 with nothing above it: no scan starts
    @(negedge clk);
    threshold = 8'd8;
    set_src(1, 7);
    set_src(3, 8);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check("no_scan_busy_cycles", cnt, 0);

    // Scan started at threshold 7, threshold raised to 8 once scanning
    threshold = 8'd7;
    @(negedge clk);
    threshold = 8'd8;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy) cnt++;
      @(negedge clk);
    end
    check("empty_scan_busy_cycles", cnt, SCAN_CYC);
    check("empty_scan_no_valid", irq_valid, 0);
    clear_inputs();
    @(negedge clk);

    // Withdrawal: pending drops while presented, no clear pulse
    set_src(6, 4);
    expect_grant(6, 4);
    wait_valid("s4_timeout", ok);
    if (ok) begin
      src_pending[6] = 1'b0;
      @(negedge clk);
      check("withdraw_valid", irq_valid, 0);
      repeat (3) @(negedge clk);
      check("withdraw_idle", busy, 0);
    end
    clear_inputs();
    @(negedge clk);

    // Reset in the middle of a scan, then a fresh regrant
    set_src(5, 3);
    repeat (RST_DLY) @(negedge clk);
    check("mid_scan_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_scan");
    rst = 1'b0;
    expect_grant(5, 3);
    wait_valid("s5a_timeout", ok);
    if (ok) claim(5);
    clear_inputs();
    @(negedge clk);

    // Reset while presenting, then regrant and claim
    set_src(10, 9);
    expect_grant(10, 9);
    wait_valid("s5b_timeout", ok);
    if (ok) begin
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("rst_present");
      rst = 1'b0;
      expect_grant(10, 9);
      wait_valid("s5b_regrant_timeout", ok);
      if (ok) claim(10);
    end
    clear_inputs();
    repeat (4) @(negedge clk);

    check("grant_queue_empty", exp_grant.size(), 0);
    check("clear_queue_empty", exp_clear.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
